packet_transfer_arbiter: RTL and testbench

Packet-atomic arbiter feeding the router's single transfer port from two completed-packet sources: forwarded NoC traffic and CPU-injected traffic. Grants one source per packet (head through tail), registers the outgoing flit, and presents the latched head flit and source tag the router uses for route computation. Sits between the two packet buffers and the router inside the packet controller.

---
 rtl/packet_transfer_arbiter.sv | 178 +++++++++++++++++
 tb/tb_packet_transfer_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_transfer_arbiter.sv
// packet_transfer_arbiter: packet-atomic NoC/CPU arbiter driving the router transfer port.
// Optional mid-packet stall watchdog enabled by defining PACKET_ARBITER_WATCHDOG_EN.
package types;
   typedef logic [31:0] flit_t;
endpackage

module packet_transfer_arbiter #(
   parameter int NOC_BURST = 2
`ifdef PACKET_ARBITER_WATCHDOG_EN
  ,parameter int WATCHDOG_CYCLES = 255
`endif
) (
   input  logic         nocclk,
   input  logic         rst,
   input  types::flit_t noc_flit,
   input  logic         noc_flit_valid,
   input  logic         noc_flit_last,
   output logic         noc_flit_ready,
   input  types::flit_t cpu_flit,
   input  logic         cpu_flit_valid,
   input  logic         cpu_flit_last,
   output logic         cpu_flit_ready,
   output types::flit_t transfered_flit,
   output logic         transfered_flit_valid,
   input  logic         transfered_flit_ready,
   output types::flit_t transfered_head_flit,
   output logic         is_flit_from_cpu,
   output logic         arb_timeout
);

   localparam int BURST_W = $clog2(NOC_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(NOC_BURST);

   typedef enum logic [1:0] {IDLE, GRANT_NOC, GRANT_CPU} state_t;

   state_t             state_q, state_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               head_pending_q, head_pending_d;
   types::flit_t       out_flit_q, out_flit_d;
   types::flit_t       head_flit_q, head_flit_d;
   logic               out_valid_q, out_valid_d;
   logic               from_cpu_q, from_cpu_d;

   logic               out_free;
   logic               noc_accept;
   logic               cpu_accept;
   logic               accept;
   types::flit_t       accept_flit;
   logic               accept_last;

   // Source ready follows the output register so backpressure stalls the source in the same cycle.
   always_comb begin
      out_free       = !out_valid_q || transfered_flit_ready;
      noc_flit_ready = (state_q == GRANT_NOC) && out_free;
      cpu_flit_ready = (state_q == GRANT_CPU) && out_free;
      noc_accept     = noc_flit_valid && noc_flit_ready;
      cpu_accept     = cpu_flit_valid && cpu_flit_ready;
      accept         = noc_accept || cpu_accept;
      accept_flit    = cpu_accept ? cpu_flit : noc_flit;
      accept_last    = cpu_accept ? cpu_flit_last : noc_flit_last;
   end

   always_comb begin
      state_d        = state_q;
      burst_cnt_d    = burst_cnt_q;
      head_pending_d = head_pending_q;
      unique case (state_q)
         IDLE: begin
            head_pending_d = 1'b1;
            if (noc_flit_valid && cpu_flit_valid) begin
               if (burst_cnt_q == BURST_MAX) begin
                  state_d     = GRANT_CPU;
                  burst_cnt_d = '0;
               end else begin
                  state_d     = GRANT_NOC;
                  burst_cnt_d = burst_cnt_q + 1'b1;
               end
            end else if (noc_flit_valid) begin
               state_d     = GRANT_NOC;
               burst_cnt_d = '0;
            end else if (cpu_flit_valid) begin
               state_d     = GRANT_CPU;
               burst_cnt_d = '0;
            end
         end
         GRANT_NOC, GRANT_CPU: begin
            if (accept) begin
               head_pending_d = 1'b0;
               if (accept_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      from_cpu_d  = from_cpu_q;
      head_flit_d = head_flit_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_flit_d  = accept_flit;
         from_cpu_d  = cpu_accept;
         if (head_pending_q) begin
            head_flit_d = accept_flit;
         end
      end else if (transfered_flit_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         burst_cnt_q    <= '0;
         head_pending_q <= 1'b1;
         out_valid_q    <= 1'b0;
         out_flit_q     <= '0;
         from_cpu_q     <= 1'b0;
         head_flit_q    <= '0;
      end else begin
         state_q        <= state_d;
         burst_cnt_q    <= burst_cnt_d;
         head_pending_q <= head_pending_d;
         out_valid_q    <= out_valid_d;
         out_flit_q     <= out_flit_d;
         from_cpu_q     <= from_cpu_d;
         head_flit_q    <= head_flit_d;
      end
   end

   assign transfered_flit       = out_flit_q;
   assign transfered_flit_valid = out_valid_q;
   assign transfered_head_flit  = head_flit_q;
   assign is_flit_from_cpu      = from_cpu_q;

`ifdef PACKET_ARBITER_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);

   logic [WD_W-1:0] stall_cnt_q, stall_cnt_d;
   logic            timeout_q, timeout_d;
   logic            src_valid;

   // Only stalls after the head has been taken count; the grant itself is never released.
   always_comb begin
      src_valid   = (state_q == GRANT_CPU) ? cpu_flit_valid : noc_flit_valid;
      stall_cnt_d = stall_cnt_q;
      timeout_d   = timeout_q;
      if ((state_q == IDLE) || accept) begin
         stall_cnt_d = '0;
      end else if (!head_pending_q && !src_valid && (stall_cnt_q != WD_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (stall_cnt_d == WD_MAX) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign arb_timeout = timeout_q;
`else
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_packet_transfer_arbiter.sv
// Self-checking bench for packet_transfer_arbiter: source queues, output scoreboard, vector table.
module tb_packet_transfer_arbiter;
   import types::*;

   logic  nocclk = 1'b0;
   always #5 nocclk = ~nocclk;

   logic  rst;
   flit_t noc_flit, cpu_flit, transfered_flit, transfered_head_flit;
   logic  noc_flit_valid, noc_flit_last, noc_flit_ready;
   logic  cpu_flit_valid, cpu_flit_last, cpu_flit_ready;
   logic  transfered_flit_valid, transfered_flit_ready;
   logic  is_flit_from_cpu, arb_timeout;

   packet_transfer_arbiter #(
      .NOC_BURST(2)
`ifdef PACKET_ARBITER_WATCHDOG_EN
     ,.WATCHDOG_CYCLES(8)
`endif
   ) dut (
      .nocclk(nocclk),
      .rst(rst),
      .noc_flit(noc_flit),
      .noc_flit_valid(noc_flit_valid),
      .noc_flit_last(noc_flit_last),
      .noc_flit_ready(noc_flit_ready),
      .cpu_flit(cpu_flit),
      .cpu_flit_valid(cpu_flit_valid),
      .cpu_flit_last(cpu_flit_last),
      .cpu_flit_ready(cpu_flit_ready),
      .transfered_flit(transfered_flit),
      .transfered_flit_valid(transfered_flit_valid),
      .transfered_flit_ready(transfered_flit_ready),
      .transfered_head_flit(transfered_head_flit),
      .is_flit_from_cpu(is_flit_from_cpu),
      .arb_timeout(arb_timeout)
   );

   typedef struct { flit_t flit; logic last; int gap; } src_item_t;
   typedef struct { flit_t flit; logic cpu; flit_t head; int gap; } exp_t;
   typedef struct { logic cpu; flit_t flit; int lat; } vec_t;

   src_item_t noc_q[$];
   src_item_t cpu_q[$];
   exp_t      sb[$];
   int        noc_wait, cpu_wait;
   int        errors = 0;
   int        checks = 0;
   int        idle_run;
   logic      hold_pending;
   flit_t     hold_flit;
   logic      rr_toggle;
   logic      last_noc_acc;
   logic      exp_timeout;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      noc_flit_valid = (noc_q.size() > 0) && (noc_wait == 0);
      cpu_flit_valid = (cpu_q.size() > 0) && (cpu_wait == 0);
      noc_flit = '0; noc_flit_last = 1'b0;
      cpu_flit = '0; cpu_flit_last = 1'b0;
      if (noc_q.size() > 0) begin
         noc_flit      = noc_q[0].flit;
         noc_flit_last = noc_q[0].last;
      end
      if (cpu_q.size() > 0) begin
         cpu_flit      = cpu_q[0].flit;
         cpu_flit_last = cpu_q[0].last;
      end
   endtask

   // Push a packet into its source queue and its expected flits into the scoreboard.
   task automatic push_pkt(input logic cpu, input flit_t base, input int len,
                           input int head_gap, input int body_gap, input int stall1);
      src_item_t it;
      exp_t      e;
      for (int i = 0; i < len; i++) begin
         it.flit = base + flit_t'(i);
         it.last = (i == len - 1);
         it.gap  = (i == 1) ? stall1 : 0;
         if (cpu) begin
            if (cpu_q.size() == 0) cpu_wait = it.gap;
            cpu_q.push_back(it);
         end else begin
            if (noc_q.size() == 0) noc_wait = it.gap;
            noc_q.push_back(it);
         end
         e.flit = it.flit;
         e.cpu  = cpu;
         e.head = base;
         e.gap  = (i == 0) ? head_gap : body_gap;
         sb.push_back(e);
      end
   endtask

   task automatic step();
      logic na, ca;
      exp_t e;
      @(negedge nocclk);
      na = noc_flit_valid && noc_flit_ready;
      ca = cpu_flit_valid && cpu_flit_ready;
      last_noc_acc = na;
      if (hold_pending) begin
         chk("hold_stable", 64'({transfered_flit_valid, transfered_flit}), 64'({1'b1, hold_flit}));
         hold_pending = 1'b0;
      end
      if (transfered_flit_valid && transfered_flit_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit: got %0h expected none", transfered_flit);
         end else begin
            e = sb.pop_front();
            chk("flit", 64'(transfered_flit), 64'(e.flit));
            chk("tag", 64'(is_flit_from_cpu), 64'(e.cpu));
            chk("head", 64'(transfered_head_flit), 64'(e.head));
            if (e.gap >= 0) chk("gap", 64'(idle_run), 64'(e.gap));
         end
         idle_run = 0;
      end else if (transfered_flit_valid) begin
         hold_pending = 1'b1;
         hold_flit    = transfered_flit;
      end else begin
         idle_run++;
      end
      @(posedge nocclk);
      #1;
      if (na) begin
         void'(noc_q.pop_front());
         if (noc_q.size() > 0) noc_wait = noc_q[0].gap;
      end else if (noc_wait > 0) begin
         noc_wait--;
      end
      if (ca) begin
         void'(cpu_q.pop_front());
         if (cpu_q.size() > 0) cpu_wait = cpu_q[0].gap;
      end else if (cpu_wait > 0) begin
         cpu_wait--;
      end
      if (rr_toggle) transfered_flit_ready = ~transfered_flit_ready;
      drive();
   endtask

   task automatic run_until_empty(input int max_steps, output int n);
      n = 0;
      while ((sb.size() > 0) && (n < max_steps)) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vec_t vt[6];
      int   n;
      vt[0] = '{1'b1, 32'hC000_0001, 3};
      vt[1] = '{1'b0, 32'hA000_0002, 3};
      vt[2] = '{1'b1, 32'hC000_0003, 3};
      vt[3] = '{1'b0, 32'hA000_0004, 3};
      vt[4] = '{1'b1, 32'hC000_0005, 3};
      vt[5] = '{1'b0, 32'hA000_0006, 3};
`ifdef PACKET_ARBITER_WATCHDOG_EN
      exp_timeout = 1'b1;
`else
      exp_timeout = 1'b0;
`endif

      rst = 1'b1;
      transfered_flit_ready = 1'b1;
      rr_toggle = 1'b0;
      noc_wait = 0; cpu_wait = 0; idle_run = 0; hold_pending = 1'b0; last_noc_acc = 1'b0;
      drive();
      repeat (3) @(posedge nocclk);
      #1;
      chk("rst_valid", 64'(transfered_flit_valid), 64'(0));
      chk("rst_flit", 64'(transfered_flit), 64'(0));
      chk("rst_head", 64'(transfered_head_flit), 64'(0));
      chk("rst_tag", 64'(is_flit_from_cpu), 64'(0));
      chk("rst_noc_ready", 64'(noc_flit_ready), 64'(0));
      chk("rst_cpu_ready", 64'(cpu_flit_ready), 64'(0));
      chk("rst_timeout", 64'(arb_timeout), 64'(0));
      rst = 1'b0;
      repeat (2) step();

      // Single NoC source, 4 flits back to back.
      push_pkt(1'b0, 32'h1000_0000, 4, -1, 0, 0);
      drive();
      run_until_empty(30, n);
      repeat (2) step();

      // Contention with NOC_BURST=2: N, N, C, N, N, C with one bubble per packet.
      push_pkt(1'b0, 32'h2000_0000, 3, -1, 0, 0);
      push_pkt(1'b0, 32'h2100_0000, 3, 1, 0, 0);
      push_pkt(1'b1, 32'h2C00_0000, 3, 1, 0, 0);
      push_pkt(1'b0, 32'h2200_0000, 3, 1, 0, 0);
      push_pkt(1'b0, 32'h2300_0000, 3, 1, 0, 0);
      push_pkt(1'b1, 32'h2D00_0000, 3, 1, 0, 0);
      drive();
      run_until_empty(60, n);
      repeat (2) step();

      // Router ready toggling on a 5-flit CPU packet.
      rr_toggle = 1'b1;
      push_pkt(1'b1, 32'h3000_0000, 5, -1, -1, 0);
      drive();
      run_until_empty(40, n);
      rr_toggle = 1'b0;
      transfered_flit_ready = 1'b1;
      repeat (3) step();

      // Single-flit packets from one source at a time: fixed latency, tag and head.
      for (int i = 0; i < 6; i++) begin
         push_pkt(vt[i].cpu, vt[i].flit, 1, -1, 0, 0);
         drive();
         run_until_empty(20, n);
         chk("single_latency", 64'(n), 64'(vt[i].lat));
      end
      repeat (2) step();

      // Reset in the middle of a CPU packet.
      push_pkt(1'b1, 32'h5000_0000, 6, -1, 0, 0);
      drive();
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(transfered_flit_valid), 64'(0));
      chk("mid_rst_flit", 64'(transfered_flit), 64'(0));
      chk("mid_rst_head", 64'(transfered_head_flit), 64'(0));
      chk("mid_rst_tag", 64'(is_flit_from_cpu), 64'(0));
      chk("mid_rst_cpu_ready", 64'(cpu_flit_ready), 64'(0));
      noc_q.delete(); cpu_q.delete(); sb.delete();
      noc_wait = 0; cpu_wait = 0; hold_pending = 1'b0;
      drive();
      repeat (2) step();
      rst = 1'b0;
      push_pkt(1'b0, 32'h6000_0000, 3, -1, 0, 0);
      drive();
      run_until_empty(20, n);
      repeat (2) step();

      // NoC head then a 10-cycle source stall mid-packet.
      push_pkt(1'b0, 32'h7000_0000, 3, -1, -1, 10);
      drive();
      n = 0;
      do begin
         step();
         n++;
      end while (!last_noc_acc && n < 10);
      chk("wd_head_accepted", 64'(last_noc_acc), 64'(1));
      repeat (6) step();
      chk("wd_before_limit", 64'(arb_timeout), 64'(0));
      repeat (4) step();
      chk("wd_after_limit", 64'(arb_timeout), 64'(exp_timeout));
      run_until_empty(30, n);
      repeat (2) step();
      chk("wd_sticky", 64'(arb_timeout), 64'(exp_timeout));

      chk("final_out_idle", 64'(transfered_flit_valid), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
